// File: rtl/usb_reg_fe_burst.sv
// -----------------------------------------------------------------------------
// usb_reg_fe_burst
//
// Host-bus register frontend. Converts the asynchronous host parallel bus
// (addr/din/rdn/wrn/alen/cen) into single-cycle register read and write
// strobes in the usb_clk domain. A latched address supplies a register base
// plus a byte counter that auto-increments after every completed access, so
// a host can burst through the bytes of one register without re-latching.
//
// Optional feature (compile-time macro USB_REG_FE_TIMEOUT_EN):
//   defined   : a watchdog aborts a sequence stuck in WR_WAIT, RD_DLY or
//               RD_HOLD for pTIMEOUT cycles and sets the sticky timeout_flag.
//   undefined : no watchdog is built, timeout_flag is tied low.
//
// Ports
//   usb_clk        in   sole clock
//   rst            in   asynchronous active-high reset
//   usb_din        in   host write data
//   usb_dout       out  registered read data to host
//   usb_isout      out  host data-bus output enable
//   usb_addr       in   host address
//   usb_rdn        in   read strobe, active-low
//   usb_wrn        in   write strobe, active-low
//   usb_alen       in   address latch enable, active-low
//   usb_cen        in   chip enable, active-low
//   reg_address    out  register select (address high bits)
//   reg_bytecnt    out  byte within register (address low bits / counter)
//   reg_datao      out  write data to registers
//   reg_datai      in   read data from registers
//   reg_read       out  one-cycle read pulse
//   reg_write      out  one-cycle write pulse
//   reg_addrvalid  out  address latched and current
//   proto_err      out  sticky protocol error
//   timeout_flag   out  sticky watchdog flag
// -----------------------------------------------------------------------------
module usb_reg_fe_burst #(
  parameter int pADDR_WIDTH    = 21,
  parameter int pBYTECNT_SIZE  = 7,
  parameter int pDATA_WIDTH    = 8,
  parameter int pREG_RDDLY_LEN = 3,
  parameter int pISOUT_HOLD    = 2,
  parameter int pTIMEOUT       = 1024
) (
  input  logic                                 usb_clk,
  input  logic                                 rst,
  input  logic [pDATA_WIDTH-1:0]               usb_din,
  output logic [pDATA_WIDTH-1:0]               usb_dout,
  output logic                                 usb_isout,
  input  logic [pADDR_WIDTH-1:0]               usb_addr,
  input  logic                                 usb_rdn,
  input  logic                                 usb_wrn,
  input  logic                                 usb_alen,
  input  logic                                 usb_cen,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [pDATA_WIDTH-1:0]               reg_datao,
  input  logic [pDATA_WIDTH-1:0]               reg_datai,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid,
  output logic                                 proto_err,
  output logic                                 timeout_flag
);

  localparam int BASE_W = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int DLY_W  = $clog2(pREG_RDDLY_LEN + 1);
  localparam int HOLD_W = $clog2(pISOUT_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_WAIT,
    RD,
    RD_DLY,
    RD_HOLD,
    ISOUT_TAIL
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisation and sampling
  // ---------------------------------------------------------------------------
  logic [1:0]             rdn_sync, wrn_sync, alen_sync, cen_sync;
  logic                   rdn_prev, wrn_prev;
  logic [pADDR_WIDTH-1:0] addr_r;
  logic [pDATA_WIDTH-1:0] din_r;

  logic rdn_s, wrn_s, alen_s, cen_s;
  logic rd_fall, wr_fall;

  assign rdn_s  = rdn_sync[1];
  assign wrn_s  = wrn_sync[1];
  assign alen_s = alen_sync[1];
  assign cen_s  = cen_sync[1];

  // A falling edge needs a high history sample, so a strobe that is held low
  // across reset never starts an access after release.
  assign rd_fall = rdn_prev & ~rdn_s;
  assign wr_fall = wrn_prev & ~wrn_s;

  // NOTE: every flop uses non-blocking assignment so all registers update from
  // the pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      // Strobe chains reset to "low" so a strobe must be seen high after reset
      // before a fall counts; alen/cen reset inactive so no address is loaded.
      rdn_sync  <= 2'b00;
      wrn_sync  <= 2'b00;
      alen_sync <= 2'b11;
      cen_sync  <= 2'b11;
      rdn_prev  <= 1'b0;
      wrn_prev  <= 1'b0;
      addr_r    <= '0;
      din_r     <= '0;
    end else begin
      rdn_sync  <= {rdn_sync[0],  usb_rdn};
      wrn_sync  <= {wrn_sync[0],  usb_wrn};
      alen_sync <= {alen_sync[0], usb_alen};
      cen_sync  <= {cen_sync[0],  usb_cen};
      rdn_prev  <= rdn_s;
      wrn_prev  <= wrn_s;
      addr_r    <= usb_addr;
      din_r     <= usb_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched address, byte counter and access sequencer
  // ---------------------------------------------------------------------------
  state_t                   state;
  logic [BASE_W-1:0]        base;
  logic [pBYTECNT_SIZE-1:0] bcnt;
  logic [DLY_W-1:0]         dly_cnt;
  logic [HOLD_W-1:0]        tail_cnt;

`ifdef USB_REG_FE_TIMEOUT_EN
  localparam int TO_W = $clog2(pTIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_active;

  assign to_active = (state == WR_WAIT) || (state == RD_DLY) || (state == RD_HOLD);
`else
  assign timeout_flag = 1'b0;
`endif

  // Without a current latch the host address is passed straight through.
  assign reg_address = reg_addrvalid ? base : addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
  assign reg_bytecnt = reg_addrvalid ? bcnt : addr_r[pBYTECNT_SIZE-1:0];

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_datao     <= '0;
      usb_dout      <= '0;
      usb_isout     <= 1'b0;
      proto_err     <= 1'b0;
      dly_cnt       <= '0;
      tail_cnt      <= '0;
      base          <= '0;
      bcnt          <= '0;
      reg_addrvalid <= 1'b0;
`ifdef USB_REG_FE_TIMEOUT_EN
      to_cnt        <= '0;
      timeout_flag  <= 1'b0;
`endif
    end else begin
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
`ifdef USB_REG_FE_TIMEOUT_EN
      // Cleared on every cycle that does not stay in a watched state, which
      // restarts the count on each state entry.
      to_cnt    <= '0;
`endif

      if (state != IDLE && cen_s) begin
        // Chip deselected mid-sequence: drop everything, no counter update.
        state     <= IDLE;
        usb_isout <= 1'b0;
`ifdef USB_REG_FE_TIMEOUT_EN
      end else if (to_active && to_cnt == TO_W'(pTIMEOUT - 1)) begin
        state        <= IDLE;
        usb_isout    <= 1'b0;
        timeout_flag <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (!cen_s) begin
              if (wr_fall && rd_fall) begin
                proto_err <= 1'b1;
              end else if (wr_fall) begin
                state     <= WR;
                reg_write <= 1'b1;
                reg_datao <= din_r;
              end else if (rd_fall) begin
                state     <= RD;
                reg_read  <= 1'b1;
                usb_isout <= 1'b1;
                dly_cnt   <= '0;
              end
            end
          end

          WR: state <= WR_WAIT;

          WR_WAIT: begin
            if (wrn_s) begin
              if (reg_addrvalid) bcnt <= bcnt + 1'b1;
              state <= IDLE;
            end else begin
`ifdef USB_REG_FE_TIMEOUT_EN
              to_cnt <= to_cnt + 1'b1;
`endif
            end
          end

          // The read delay counts from the reg_read cycle, so RD is the first
          // counted cycle. rdn is ignored here: capture always completes.
          RD, RD_DLY: begin
            if (dly_cnt == DLY_W'(pREG_RDDLY_LEN - 1)) begin
              usb_dout <= reg_datai;
              state    <= RD_HOLD;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
              state   <= RD_DLY;
`ifdef USB_REG_FE_TIMEOUT_EN
              if (state == RD_DLY) to_cnt <= to_cnt + 1'b1;
`endif
            end
          end

          RD_HOLD: begin
            if (rdn_s) begin
              if (reg_addrvalid) bcnt <= bcnt + 1'b1;
              tail_cnt <= '0;
              state    <= ISOUT_TAIL;
            end else begin
`ifdef USB_REG_FE_TIMEOUT_EN
              to_cnt <= to_cnt + 1'b1;
`endif
            end
          end

          // Keeps the host bus driven a little after the strobe releases.
          ISOUT_TAIL: begin
            if (tail_cnt == HOLD_W'(pISOUT_HOLD - 1)) begin
              usb_isout <= 1'b0;
              state     <= IDLE;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end

          default: begin
            state     <= IDLE;
            usb_isout <= 1'b0;
          end
        endcase
      end

      // The opposite strobe falling during a sequence is flagged only; the
      // sequence in flight is allowed to finish.
      if ((state == WR || state == WR_WAIT) && rd_fall) proto_err <= 1'b1;
      if ((state == RD || state == RD_DLY || state == RD_HOLD || state == ISOUT_TAIL)
          && wr_fall) proto_err <= 1'b1;

      // Address latch overrides any increment issued in the same cycle.
      if (!alen_s && !cen_s) begin
        base          <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
        bcnt          <= addr_r[pBYTECNT_SIZE-1:0];
        reg_addrvalid <= 1'b1;
      end else if (cen_s) begin
        reg_addrvalid <= 1'b0;
      end
    end
  end

endmodule
